pseudo_spi_rw_engine: RTL and testbench

// Parametrised, bidirectional successor to the pseudo-SPI SRAM port. It streams DATA_LEN words between an
// RA1SH-style single-port SRAM (CEN/WEN active-low, 1-cycle Q) and a two-phase serial link (SCLK1/SCLK2/LAT).

---
 rtl/pseudo_spi_rw_engine_pkg.sv | 38 +++
 rtl/pseudo_spi_rw_engine_spi_phase_gen.sv | 66 ++++++
 rtl/pseudo_spi_rw_engine.sv | 190 +++++++++++++++++++
 tb/tb_pseudo_spi_rw_engine.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_spi_rw_engine_pkg.sv
// Shared types for the pseudo-SPI read/write engine: FSM states, bit-cell phases, mode codes.
package pseudo_spi_rw_engine_pkg;

   // Main controller states.
   typedef enum logic [3:0] {
      StIdle  = 4'd0,
      StAddr  = 4'd1,
      StRead  = 4'd2,
      StLoad  = 4'd3,
      StShift = 4'd4,
      StLatch = 4'd5,
      StWrite = 4'd6,
      StLoop  = 4'd7,
      StDone  = 4'd8
   } state_e;

   // Four ticks per serial bit cell.
   typedef enum logic [1:0] {
      PhT0 = 2'd0,  // data setup
      PhT1 = 2'd1,  // sclk1 high
      PhT2 = 2'd2,  // both clocks low
      PhT3 = 2'd3   // sclk2 high, serial input sampled at its end
   } phase_e;

   localparam logic ModeDump = 1'b0;  // SRAM -> spi_so
   localparam logic ModeLoad = 1'b1;  // spi_si -> SRAM

   // States in which the SRAM is enabled.
   function automatic logic is_sram_state(input state_e s);
      return (s == StRead) || (s == StWrite);
   endfunction

   // States in which the bit-cell clock generator runs.
   function automatic logic is_clk_state(input state_e s);
      return (s == StShift) || (s == StLatch);
   endfunction

endpackage

// File: rtl/pseudo_spi_rw_engine_spi_phase_gen.sv
// Tick divider plus 2-bit phase counter producing the non-overlapping sclk1/sclk2 pair.
module spi_phase_gen
   import pseudo_spi_rw_engine_pkg::*;
#(
   parameter int unsigned DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,     // next-cycle enable, so outputs drop together with the FSM
   input  logic [DIV_WIDTH-1:0] div,    // tick every div+1 cycles
   output logic                 tick,   // last cycle of the current tick period
   output phase_e               phase,
   output logic                 sclk1,
   output logic                 sclk2
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   phase_e               phase_q, phase_d;
   logic                 active_q, active_d;
   logic                 sclk1_q, sclk1_d;
   logic                 sclk2_q, sclk2_d;

   assign tick  = active_q && (cnt_q == div);
   assign phase = phase_q;
   assign sclk1 = sclk1_q;
   assign sclk2 = sclk2_q;

   // Next-state: restart at T0 on the first enabled cycle, then advance one phase per tick.
   always_comb begin
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      active_d = en;
      if (!en || !active_q) begin
         cnt_d   = '0;
         phase_d = PhT0;
      end else if (tick) begin
         cnt_d   = '0;
         phase_d = phase_e'(phase_q + 2'd1);
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      // Clocks are decoded from the next phase so they come straight out of flops.
      sclk1_d = en && (phase_d == PhT1);
      sclk2_d = en && (phase_d == PhT3);
   end

   // Divider/phase state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         phase_q  <= PhT0;
         active_q <= 1'b0;
         sclk1_q  <= 1'b0;
         sclk2_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         active_q <= active_d;
         sclk1_q  <= sclk1_d;
         sclk2_q  <= sclk2_d;
      end
   end

   sclk_no_overlap_a : assert property (@(posedge clk) disable iff (!rst_n) !(sclk1_q && sclk2_q));

endmodule

// File: rtl/pseudo_spi_rw_engine.sv
// Streams data_len words between a single-port SRAM and a two-phase serial link, in either
// direction. All outputs come from flops loaded with values decoded from the next state.
module pseudo_spi_rw_engine
   import pseudo_spi_rw_engine_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bgn,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] addr_bgn,
   input  logic [LEN_WIDTH-1:0]  data_len,
   input  logic [DIV_WIDTH-1:0]  freq_div,
   input  logic [DATA_WIDTH-1:0] pi,
   input  logic                  spi_si,
   output logic                  sclk1,
   output logic                  sclk2,
   output logic                  lat,
   output logic                  spi_so,
   output logic                  cen,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] a,
   output logic [DATA_WIDTH-1:0] po,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

   state_e                state_q, state_d;
   logic                  mode_q, mode_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [LEN_WIDTH-1:0]  count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;

   logic                  cen_q, cen_d;
   logic                  wen_q, wen_d;
   logic                  lat_q, lat_d;
   logic                  so_q, so_d;
   logic [DATA_WIDTH-1:0] po_q, po_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  tick;
   phase_e                phase;
   logic                  shift_in;

   spi_phase_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_phase_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (is_clk_state(state_d)),
      .div   (div_q),
      .tick  (tick),
      .phase (phase),
      .sclk1 (sclk1),
      .sclk2 (sclk2)
   );

   // Dump shifts zeros in behind the outgoing LSB; load fills from the MSB side.
   assign shift_in = (mode_q == ModeLoad) ? spi_si : 1'b0;

   // Controller next-state, transfer counters and shift register.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      div_d     = div_q;
      count_d   = count_q;
      addr_d    = addr_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (bgn) begin
               mode_d    = mode;
               div_d     = freq_div;
               count_d   = data_len;
               addr_d    = addr_bgn;
               bit_cnt_d = '0;
               state_d   = (data_len == '0) ? StDone : StAddr;
            end
         end
         StAddr:  state_d = (mode_q == ModeDump) ? StRead : StShift;
         StRead:  state_d = StLoad;
         StLoad: begin
            shreg_d = pi;
            state_d = StShift;
         end
         StShift: begin
            // A bit cell completes on the tick that ends T3.
            if (tick && (phase == PhT3)) begin
               shreg_d = {shift_in, shreg_q[DATA_WIDTH-1:1]};
               if (bit_cnt_q == LastBit) begin
                  bit_cnt_d = '0;
                  state_d   = StLatch;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StLatch: begin
            if (tick) begin
               state_d = (mode_q == ModeLoad) ? StWrite : StLoop;
            end
         end
         StWrite: state_d = StLoop;
         StLoop: begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q - 1'b1;
            state_d = (count_q == LEN_WIDTH'(1)) ? StDone : StAddr;
         end
         StDone:  state_d = StDone;
         default: state_d = StIdle;
      endcase

      // bgn is a level enable: dropping it ends DONE and aborts anything in flight.
      if (!bgn) begin
         state_d = StIdle;
      end
      if (state_d == StIdle) begin
         addr_d    = '0;
         bit_cnt_d = '0;
      end
   end

   // Registered outputs decoded from the next state.
   always_comb begin
      cen_d  = !is_sram_state(state_d);
      wen_d  = (state_d != StWrite);
      lat_d  = (state_d == StLatch);
      so_d   = ((state_d == StShift) && (mode_d == ModeDump)) ? shreg_d[0] : 1'b0;
      po_d   = (state_d == StWrite) ? shreg_d : '0;
      busy_d = (state_d != StIdle) && (state_d != StDone);
      done_d = (state_d == StDone);
   end

   // Controller and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mode_q    <= ModeDump;
         div_q     <= '0;
         count_q   <= '0;
         addr_q    <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         cen_q     <= 1'b1;
         wen_q     <= 1'b1;
         lat_q     <= 1'b0;
         so_q      <= 1'b0;
         po_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         div_q     <= div_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         cen_q     <= cen_d;
         wen_q     <= wen_d;
         lat_q     <= lat_d;
         so_q      <= so_d;
         po_q      <= po_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign cen    = cen_q;
   assign wen    = wen_q;
   assign lat    = lat_q;
   assign spi_so = so_q;
   assign a      = addr_q;
   assign po     = po_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_pseudo_spi_rw_engine.sv
// Scoreboard bench: transfers push expected SRAM accesses and serial frames into queues; monitors
// pop and compare as the DUT produces them. SRAM and serial source are modelled here.
module tb_pseudo_spi_rw_engine;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bgn;
   logic       mode;
   logic [8:0] addr_bgn;
   logic [7:0] data_len;
   logic [7:0] freq_div;
   logic [7:0] pi;
   logic       spi_si = 1'b0;
   logic       sclk1, sclk2, lat, spi_so, cen, wen, busy, done;
   logic [8:0] a;
   logic [7:0] po;

   pseudo_spi_rw_engine dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bgn      (bgn),
      .mode     (mode),
      .addr_bgn (addr_bgn),
      .data_len (data_len),
      .freq_div (freq_div),
      .pi       (pi),
      .spi_si   (spi_si),
      .sclk1    (sclk1),
      .sclk2    (sclk2),
      .lat      (lat),
      .spi_so   (spi_so),
      .cen      (cen),
      .wen      (wen),
      .a        (a),
      .po       (po),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  mem [512];
   int unsigned exp_rd[$];
   logic [16:0] exp_wr[$];    // {addr, data}
   logic [7:0]  exp_frame[$];
   bit          si_bits[$];
   logic [7:0]  given [4];
   bit          cur_mode = 1'b0;
   int          rd_cnt = 0, wr_cnt = 0, lat_cnt = 0, overlap_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SRAM model and access scoreboard (1-cycle Q).
   always @(posedge clk) begin
      if (rst_n && !cen) begin
         if (!wen) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL wr_unexpected: write addr %0d data %0h", a, po);
            end else begin
               logic [16:0] e;
               e = exp_wr.pop_front();
               check("wr_addr", 32'(a), 32'(e[16:8]));
               check("wr_data", 32'(po), 32'(e[7:0]));
            end
            mem[a] <= po;
         end else begin
            rd_cnt++;
            if (exp_rd.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL rd_unexpected: read addr %0d", a);
            end else begin
               check("rd_addr", 32'(a), exp_rd.pop_front());
            end
            pi <= mem[a];
         end
      end
   end

   // Serial source: present the next bit while sclk1 is high; sampled at the end of T3.
   always @(posedge sclk1) begin
      if (si_bits.size() > 0) spi_si = si_bits.pop_front();
      else spi_si = 1'b0;
   end

   // Serial monitor: assemble dump frames LSB first and compare on each LAT pulse.
   logic [7:0] frame = '0;
   int         bit_idx = 0;
   logic       sclk1_prev = 1'b0, lat_prev = 1'b0;
   always @(negedge clk) begin
      if (sclk1 && sclk2) overlap_cnt++;
      if (sclk1 && !sclk1_prev && cur_mode == 1'b0 && bit_idx < 8) begin
         frame[bit_idx[2:0]] = spi_so;
         bit_idx++;
      end
      if (lat && !lat_prev) begin
         lat_cnt++;
         if (cur_mode == 1'b0) begin
            if (exp_frame.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL frame_unexpected: frame %0h", frame);
            end else begin
               check("frame", 32'(frame), 32'(exp_frame.pop_front()));
            end
         end
         bit_idx = 0;
      end
      if (!busy) bit_idx = 0;
      sclk1_prev = sclk1;
      lat_prev   = lat;
   end

   // One full transfer; called at a negedge with bgn low and the DUT idle.
   task automatic run_xfer(input bit m, input int unsigned addr, input int unsigned len,
                           input int unsigned div, input bit use_given);
      int unsigned p, d, n, lat0, rd0, wr0;
      bit          got;
      logic [7:0]  f;
      d    = div + 1;
      p    = (m == 1'b0) ? (4 + 32 * d + d) : (3 + 32 * d + d);
      lat0 = lat_cnt;
      rd0  = rd_cnt;
      wr0  = wr_cnt;
      si_bits.delete();
      cur_mode = m;
      for (int i = 0; i < int'(len); i++) begin
         int unsigned wa;
         wa = (addr + i) % 512;
         if (m == 1'b0) begin
            exp_rd.push_back(wa);
            exp_frame.push_back(mem[wa]);
         end else begin
            f = (use_given && i < 4) ? given[i] : 8'($urandom);
            exp_wr.push_back({wa[8:0], f});
            for (int b = 0; b < 8; b++) si_bits.push_back(f[b]);
         end
      end
      mode     = m;
      addr_bgn = addr[8:0];
      data_len = len[7:0];
      freq_div = div[7:0];
      bgn      = 1'b1;
      got      = 1'b0;
      for (n = 1; n <= len * p + 10; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 1) begin
            // Captured already; later changes must be ignored.
            mode     = ~m;
            addr_bgn = 9'($urandom);
            data_len = 8'($urandom);
            freq_div = 8'($urandom);
         end
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: no done after %0d cycles, required %0d", n, 1 + len * p);
      end else begin
         check("latency", n, 1 + len * p);
      end
      check("lat_pulses", lat_cnt - lat0, len);
      check("sram_reads", rd_cnt - rd0, (m == 1'b0) ? len : 0);
      check("sram_writes", wr_cnt - wr0, (m == 1'b1) ? len : 0);
      bgn = 1'b0;
      @(negedge clk);
      check("idle_done", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned wr0, n, rises;
      logic        s1p;
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      rst_n    = 1'b0;
      bgn      = 1'b0;
      mode     = 1'b0;
      addr_bgn = '0;
      data_len = '0;
      freq_div = '0;
      #12;
      check("rst_sclk1", 32'(sclk1), 0);
      check("rst_sclk2", 32'(sclk2), 0);
      check("rst_lat", 32'(lat), 0);
      check("rst_so", 32'(spi_so), 0);
      check("rst_cen", 32'(cen), 1);
      check("rst_wen", 32'(wen), 1);
      check("rst_a", 32'(a), 0);
      check("rst_po", 32'(po), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Dump 14 words from 32.
      run_xfer(1'b0, 32, 14, 0, 1'b0);

      // Load fixed frames into 100..103.
      given[0] = 8'hAB;
      given[1] = 8'h3C;
      given[2] = 8'h05;
      given[3] = 8'h9E;
      run_xfer(1'b1, 100, 4, 3, 1'b1);
      for (int i = 0; i < 4; i++) check("load_mem", 32'(mem[100 + i]), 32'(given[i]));

      // Address wrap 510, 511, 0.
      run_xfer(1'b0, 510, 3, 1, 1'b0);

      // Zero length: straight to DONE, no SRAM access.
      run_xfer(1'b0, 7, 0, 0, 1'b0);

      // Randomised transfers.
      for (int k = 0; k < 6; k++) begin
         run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(1, 6),
                  $urandom_range(0, 3), 1'b0);
      end

      // Abort during word 2 of a load: only word 1 is written.
      begin
         logic [7:0] f0, f1;
         f0 = 8'($urandom);
         f1 = 8'($urandom);
         si_bits.delete();
         for (int b = 0; b < 8; b++) si_bits.push_back(f0[b]);
         for (int b = 0; b < 8; b++) si_bits.push_back(f1[b]);
         exp_wr.push_back({9'd200, f0});
         cur_mode = 1'b1;
         wr0      = wr_cnt;
         mode     = 1'b1;
         addr_bgn = 9'd200;
         data_len = 8'd4;
         freq_div = 8'd1;
         bgn      = 1'b1;
         for (n = 0; n < 3000 && wr_cnt == wr0; n++) @(negedge clk);
         check("abort_first_write", wr_cnt - wr0, 1);
         rises = 0;
         s1p   = sclk1;
         for (n = 0; n < 3000 && rises < 3; n++) begin
            @(negedge clk);
            if (sclk1 && !s1p) rises++;
            s1p = sclk1;
         end
         bgn = 1'b0;
         @(negedge clk);
         check("abort_busy", 32'(busy), 0);
         check("abort_sclk1", 32'(sclk1), 0);
         check("abort_sclk2", 32'(sclk2), 0);
         check("abort_cen", 32'(cen), 1);
         check("abort_a", 32'(a), 0);
         repeat (300) @(negedge clk);
         check("abort_writes", wr_cnt - wr0, 1);
         si_bits.delete();
      end

      // Asynchronous reset during the WRITE cycle of a load.
      begin
         logic [7:0] f0;
         f0 = 8'($urandom);
         si_bits.delete();
         for (int b = 0; b < 8; b++) si_bits.push_back(f0[b]);
         cur_mode = 1'b1;
         wr0      = wr_cnt;
         mode     = 1'b1;
         addr_bgn = 9'd300;
         data_len = 8'd1;
         freq_div = 8'd0;
         bgn      = 1'b1;
         for (n = 0; n < 300 && wen; n++) @(negedge clk);
         check("rst_mid_saw_write", 32'(wen), 0);
         rst_n = 1'b0;
         #1;
         check("rst_mid_cen", 32'(cen), 1);
         check("rst_mid_wen", 32'(wen), 1);
         check("rst_mid_busy", 32'(busy), 0);
         check("rst_mid_a", 32'(a), 0);
         check("rst_mid_po", 32'(po), 0);
         bgn = 1'b0;
         @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         check("rst_mid_writes", wr_cnt - wr0, 0);
         si_bits.delete();
      end

      // Engine still usable after the reset.
      run_xfer(1'b0, 400, 2, 2, 1'b0);

      check("sclk_overlap", overlap_cnt, 0);
      check("exp_frame_left", exp_frame.size(), 0);
      check("exp_rd_left", exp_rd.size(), 0);
      check("exp_wr_left", exp_wr.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
